// File: rtl/conv_apb_pkg.sv
// Shared definitions for the conv APB sequencer:
// register offsets, sequencer step enum, APB phase enum.
package conv_apb_pkg;

  localparam logic [31:0] OFS_START = 32'h00;
  localparam logic [31:0] OFS_DONE  = 32'h04;
  localparam logic [31:0] OFS_CNT   = 32'h08;
  localparam logic [31:0] OFS_FLEN  = 32'h0C;
  localparam logic [31:0] OFS_INCH  = 32'h10;
  localparam logic [31:0] OFS_OUTCH = 32'h14;
  localparam logic [31:0] OFS_CMD   = 32'h18;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FLEN,
    S_INCH,
    S_OUTCH,
    S_CMD,
    S_GO,
    S_POLL,
    S_GAP,
    S_RCNT,
    S_STOP,
    S_FIN
  } step_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } apb_ph_e;

endpackage

// File: rtl/apb_xfer_engine.sv
// One APB transfer per req; ack is a 1-cycle strobe in the
// completing ACCESS cycle, with rdata/err valid alongside it.
// Ports: i_clk, i_rst_n, i_req/i_addr/i_wdata/i_write (request),
//  o_ack/o_rdata/o_err (result), o_p*/i_p* (APB initiator pins).
module apb_xfer_engine
  import conv_apb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_write,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic [31:0] o_paddr,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_pwdata,
  input  logic [31:0] i_prdata,
  input  logic        i_pready,
  input  logic        i_pslverr
);

  apb_ph_e     r_ph;
  apb_ph_e     w_ph_nx;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_write;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ph <= PH_IDLE;
    else          r_ph <= w_ph_nx;
  end

  // Request only taken in IDLE: ACCESS always returns
  // to IDLE, so PSEL is low at least one cycle between
  // transfers.
  always_comb begin
    w_ph_nx = r_ph;
    unique case (r_ph)
      PH_IDLE:   if (i_req) w_ph_nx = PH_SETUP;
      PH_SETUP:  w_ph_nx = PH_ACCESS;
      PH_ACCESS: if (i_pready) w_ph_nx = PH_IDLE;
      default:   w_ph_nx = PH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (r_ph == PH_IDLE && i_req) begin
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_write <= i_write;
    end
  end

  assign o_psel    = (r_ph == PH_SETUP) ||
                     (r_ph == PH_ACCESS);
  assign o_penable = (r_ph == PH_ACCESS);
  assign o_ack     = o_penable && i_pready;
  assign o_rdata   = i_prdata;
  assign o_err     = i_pslverr;
  assign o_paddr   = r_addr;
  assign o_pwdata  = r_wdata;
  assign o_pwrite  = r_write;

endmodule

// File: rtl/conv_apb_sequencer.sv
// Job-driven APB initiator: programs the conv register file,
// starts it, polls DONE, reads clk_counter, clears start.
// Ports: CLK, RESETN, job_* (job request/result), busy,
//  PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA/PREADY/PSLVERR.
module conv_apb_sequencer
  import conv_apb_pkg::*;
#(
  parameter logic [31:0] A_START  = OFS_START,
  parameter logic [31:0] A_DONE   = OFS_DONE,
  parameter logic [31:0] A_CNT    = OFS_CNT,
  parameter logic [31:0] A_FLEN   = OFS_FLEN,
  parameter logic [31:0] A_INCH   = OFS_INCH,
  parameter logic [31:0] A_OUTCH  = OFS_OUTCH,
  parameter logic [31:0] A_CMD    = OFS_CMD,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned POLL_MAX = 1000000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [5:0]  job_flen,
  input  logic [8:0]  job_inch,
  input  logic [8:0]  job_outch,
  input  logic [2:0]  job_cmd,
  output logic        job_done,
  output logic        job_err,
  output logic [31:0] job_cycles,
  output logic        busy,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam logic [31:0] L_GAP = 32'(POLL_GAP - 1);
  localparam logic [31:0] L_MAX = 32'(POLL_MAX);

  step_e       r_st;
  step_e       w_nx;
  logic [5:0]  r_flen;
  logic [8:0]  r_inch;
  logic [8:0]  r_outch;
  logic [2:0]  r_cmd;
  logic        r_err;
  logic [31:0] r_poll;
  logic [31:0] r_gap;
  logic [31:0] r_shadow;
  logic [31:0] r_cycles;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_write;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_xerr;
  logic        w_set_err;

  apb_xfer_engine u_xfer (
    .i_clk     (CLK),
    .i_rst_n   (RESETN),
    .i_req     (w_req),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .i_write   (w_write),
    .o_ack     (w_ack),
    .o_rdata   (w_rdata),
    .o_err     (w_xerr),
    .o_paddr   (PADDR),
    .o_psel    (PSEL),
    .o_penable (PENABLE),
    .o_pwrite  (PWRITE),
    .o_pwdata  (PWDATA),
    .i_prdata  (PRDATA),
    .i_pready  (PREADY),
    .i_pslverr (PSLVERR)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_st <= S_IDLE;
    else         r_st <= w_nx;
  end

  always_comb begin
    w_nx      = r_st;
    w_req     = 1'b0;
    w_addr    = A_START;
    w_wdata   = '0;
    w_write   = 1'b1;
    w_set_err = 1'b0;
    unique case (r_st)
      S_IDLE: if (job_valid) w_nx = S_FLEN;
      S_FLEN: begin
        w_req   = 1'b1;
        w_addr  = A_FLEN;
        w_wdata = {26'b0, r_flen};
        if (w_ack) w_nx = w_xerr ? S_STOP : S_INCH;
      end
      S_INCH: begin
        w_req   = 1'b1;
        w_addr  = A_INCH;
        w_wdata = {23'b0, r_inch};
        if (w_ack) w_nx = w_xerr ? S_STOP : S_OUTCH;
      end
      S_OUTCH: begin
        w_req   = 1'b1;
        w_addr  = A_OUTCH;
        w_wdata = {23'b0, r_outch};
        if (w_ack) w_nx = w_xerr ? S_STOP : S_CMD;
      end
      S_CMD: begin
        w_req   = 1'b1;
        w_addr  = A_CMD;
        w_wdata = {29'b0, r_cmd};
        if (w_ack) w_nx = w_xerr ? S_STOP : S_GO;
      end
      S_GO: begin
        w_req   = 1'b1;
        w_addr  = A_START;
        w_wdata = 32'h1;
        if (w_ack) w_nx = w_xerr ? S_STOP : S_POLL;
      end
      S_POLL: begin
        w_req   = 1'b1;
        w_addr  = A_DONE;
        w_write = 1'b0;
        if (w_ack) begin
          if (w_xerr)
            w_nx = S_STOP;
          else if (w_rdata[0])
            w_nx = S_RCNT;
          else if (r_poll + 32'd1 >= L_MAX) begin
            w_nx      = S_STOP;
            w_set_err = 1'b1;
          end else
            w_nx = S_GAP;
        end
      end
      S_GAP: if (r_gap >= L_GAP) w_nx = S_POLL;
      S_RCNT: begin
        w_req   = 1'b1;
        w_addr  = A_CNT;
        w_write = 1'b0;
        if (w_ack) w_nx = S_STOP;
      end
      // PSLVERR on the clearing write is deliberately ignored.
      S_STOP: begin
        w_req   = 1'b1;
        w_addr  = A_START;
        w_wdata = '0;
        if (w_ack) w_nx = S_FIN;
      end
      S_FIN:   w_nx = S_IDLE;
      default: w_nx = S_IDLE;
    endcase
    if (w_ack && w_xerr && r_st != S_STOP)
      w_set_err = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_flen   <= '0;
      r_inch   <= '0;
      r_outch  <= '0;
      r_cmd    <= '0;
      r_err    <= 1'b0;
      r_poll   <= '0;
      r_gap    <= '0;
      r_shadow <= '0;
      r_cycles <= '0;
    end else begin
      if (r_st == S_IDLE && job_valid) begin
        r_flen  <= job_flen;
        r_inch  <= job_inch;
        r_outch <= job_outch;
        r_cmd   <= job_cmd;
        r_err   <= 1'b0;
        r_poll  <= '0;
      end
      if (w_set_err) r_err <= 1'b1;
      if (r_st == S_POLL && w_ack) begin
        r_poll <= r_poll + 32'd1;
        r_gap  <= '0;
      end
      if (r_st == S_GAP) r_gap <= r_gap + 32'd1;
      if (r_st == S_RCNT && w_ack) r_shadow <= w_rdata;
      // Loaded on entry to FIN so the value is valid
      // alongside job_done.
      if (r_st == S_STOP && w_ack && !r_err)
        r_cycles <= r_shadow;
    end
  end

  assign job_ready  = (r_st == S_IDLE);
  assign busy       = (r_st != S_IDLE);
  assign job_done   = (r_st == S_FIN);
  assign job_err    = job_done && r_err;
  assign job_cycles = r_cycles;

endmodule
